// File: rtl/i2c_cmd_sequencer.sv
// i2c_cmd_sequencer: queues legacy 32-bit I2C command words and issues them
// one at a time to the I2C command engine. Read commands (bit 31 set) wait
// for the engine's completion/readback and store the readback word in a
// result FIFO.
//
// Handshakes (s_wr, m_cmd, int, m_res): valid/ready. A transfer happens on a
// rising clk edge where both valid and ready are high. A producer that raises
// valid keeps it high, with its data stable, until that edge.
module i2c_cmd_sequencer #(
  parameter int          CMD_DEPTH_LOG2 = 4,
  parameter int          RES_DEPTH_LOG2 = 4,
  parameter int          TIMEOUT_BITS   = 20,
  parameter logic [31:0] TIMEOUT_WORD   = 32'hDEADDEAD
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      s_wr_valid,
  input  logic [31:0]               s_wr_data,
  output logic                      s_wr_ready,
  output logic                      m_cmd_valid,
  output logic [31:0]               m_cmd_data,
  input  logic                      m_cmd_ready,
  input  logic                      i_int_valid,
  output logic                      o_int_ready,
  input  logic [31:0]               i_rb_data,
  output logic                      m_res_valid,
  output logic [31:0]               m_res_data,
  input  logic                      m_res_ready,
  input  logic                      flush,
  output logic [CMD_DEPTH_LOG2:0]   cmd_level,
  output logic [RES_DEPTH_LOG2:0]   res_level,
  output logic                      busy,
  output logic [1:0]                err_flags,
  output logic [1:0]                dbg_state_o
);

  localparam int CMD_DEPTH = 1 << CMD_DEPTH_LOG2;
  localparam int RES_DEPTH = 1 << RES_DEPTH_LOG2;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_RB, S_PUSH} state_t;

  state_t                    state_q, state_d;
  logic [31:0]               cmd_data_q, cmd_data_d;
  logic [31:0]               rb_q, rb_d;
  logic [TIMEOUT_BITS-1:0]   tmo_q, tmo_d;
  logic                      discard_q, discard_d;
  logic [1:0]                err_q, err_d;

  // Command FIFO storage and pointers
  logic [31:0]               cmd_mem_q [CMD_DEPTH];
  logic [CMD_DEPTH_LOG2-1:0] cmd_wr_ptr_q, cmd_rd_ptr_q;
  logic [CMD_DEPTH_LOG2:0]   cmd_level_q;
  logic                      cmd_push, cmd_pop;
  logic [31:0]               cmd_head;

  // Result FIFO storage and pointers
  logic [31:0]               res_mem_q [RES_DEPTH];
  logic [RES_DEPTH_LOG2-1:0] res_wr_ptr_q, res_rd_ptr_q;
  logic [RES_DEPTH_LOG2:0]   res_level_q;
  logic                      res_push, res_pop;
  logic                      res_full;

  logic                      tmo_fire, stray;

  assign s_wr_ready  = (cmd_level_q != (CMD_DEPTH_LOG2+1)'(CMD_DEPTH));
  assign cmd_push    = s_wr_valid && s_wr_ready && !flush;
  assign cmd_head    = cmd_mem_q[cmd_rd_ptr_q];
  assign res_full    = (res_level_q == (RES_DEPTH_LOG2+1)'(RES_DEPTH));
  assign m_res_valid = (res_level_q != '0);
  assign m_res_data  = res_mem_q[res_rd_ptr_q];
  assign res_pop     = m_res_valid && m_res_ready && !flush;
  assign m_cmd_data  = cmd_data_q;
  assign cmd_level   = cmd_level_q;
  assign res_level   = res_level_q;
  assign err_flags   = err_q;
  assign busy        = (state_q != S_IDLE) || (cmd_level_q != '0);
  assign dbg_state_o = state_q;

  // Command FIFO data write (storage needs no reset)
  always_ff @(posedge clk) begin
    if (cmd_push) cmd_mem_q[cmd_wr_ptr_q] <= s_wr_data;
  end

  // Command FIFO pointers and occupancy; flush empties it
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      cmd_wr_ptr_q <= '0;
      cmd_rd_ptr_q <= '0;
      cmd_level_q  <= '0;
    end else begin
      if (cmd_push) cmd_wr_ptr_q <= cmd_wr_ptr_q + (CMD_DEPTH_LOG2)'(1);
      if (cmd_pop)  cmd_rd_ptr_q <= cmd_rd_ptr_q + (CMD_DEPTH_LOG2)'(1);
      cmd_level_q <= cmd_level_q + {{CMD_DEPTH_LOG2{1'b0}}, cmd_push}
                                 - {{CMD_DEPTH_LOG2{1'b0}}, cmd_pop};
    end
  end

  // Result FIFO data write
  always_ff @(posedge clk) begin
    if (res_push) res_mem_q[res_wr_ptr_q] <= rb_q;
  end

  // Result FIFO pointers and occupancy; flush empties it
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      res_wr_ptr_q <= '0;
      res_rd_ptr_q <= '0;
      res_level_q  <= '0;
    end else begin
      if (res_push) res_wr_ptr_q <= res_wr_ptr_q + (RES_DEPTH_LOG2)'(1);
      if (res_pop)  res_rd_ptr_q <= res_rd_ptr_q + (RES_DEPTH_LOG2)'(1);
      res_level_q <= res_level_q + {{RES_DEPTH_LOG2{1'b0}}, res_push}
                                 - {{RES_DEPTH_LOG2{1'b0}}, res_pop};
    end
  end

  // Sequencer state, issued command, captured readback, timeout counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cmd_data_q <= '0;
      rb_q       <= '0;
      tmo_q      <= '0;
      discard_q  <= 1'b0;
      err_q      <= 2'b00;
    end else begin
      state_q    <= state_d;
      cmd_data_q <= cmd_data_d;
      rb_q       <= rb_d;
      tmo_q      <= tmo_d;
      discard_q  <= discard_d;
      err_q      <= err_d;
    end
  end

  // Next-state logic and handshake outputs
  always_comb begin
    state_d     = state_q;
    cmd_data_d  = cmd_data_q;
    rb_d        = rb_q;
    tmo_d       = tmo_q;
    discard_d   = discard_q;
    cmd_pop     = 1'b0;
    res_push    = 1'b0;
    m_cmd_valid = 1'b0;
    o_int_ready = 1'b0;
    tmo_fire    = 1'b0;
    stray       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // Completion with nothing outstanding: accept and drop it.
        if (i_int_valid) begin
          o_int_ready = 1'b1;
          stray       = 1'b1;
        end
        // A read waits at the head until the result FIFO has room, so its
        // readback always has a slot when it returns.
        if ((cmd_level_q != '0) && !flush && (!cmd_head[31] || !res_full)) begin
          cmd_pop    = 1'b1;
          cmd_data_d = cmd_head;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        m_cmd_valid = 1'b1;
        if (i_int_valid) begin
          o_int_ready = 1'b1;
          stray       = 1'b1;
        end
        // A flushed read still completes its handshake; its word is dropped.
        if (flush && cmd_data_q[31]) discard_d = 1'b1;
        if (m_cmd_ready) begin
          if (cmd_data_q[31]) begin
            tmo_d   = '0;
            state_d = S_WAIT_RB;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_WAIT_RB: begin
        o_int_ready = 1'b1;
        tmo_d       = tmo_q + (TIMEOUT_BITS)'(1);
        if (flush) discard_d = 1'b1;
        // A completion on the timeout cycle takes priority over the timeout.
        if (i_int_valid) begin
          rb_d    = i_rb_data;
          state_d = S_PUSH;
        end else if (&tmo_q) begin
          rb_d     = TIMEOUT_WORD;
          tmo_fire = 1'b1;
          state_d  = S_PUSH;
        end
      end
      S_PUSH: begin
        res_push  = !discard_q && !flush;
        discard_d = 1'b0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sticky error flags: flush clears, new events in the same cycle still set
  always_comb begin
    err_d = flush ? 2'b00 : err_q;
    if (tmo_fire) err_d[0] = 1'b1;
    if (stray)    err_d[1] = 1'b1;
  end

endmodule
